// File: rtl/instruction_memory_responder_if.sv
// Fetch and program-load handshake bundle between the CPU/host side and the
// instruction memory responder.
interface instruction_memory_responder_if #(
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11
);
    logic                         memory_valid;
    logic [MEMORY_ADDR_WIDTH-1:0] memory_addr;
    logic                         memory_ready;
    logic [MEMORY_WIDTH-1:0]      memory_data;
    logic                         load_valid;
    logic [MEMORY_ADDR_WIDTH-1:0] load_addr;
    logic [MEMORY_WIDTH-1:0]      load_data;
    logic                         load_ready;

    modport master (
        output memory_valid, memory_addr, load_valid, load_addr, load_data,
        input  memory_ready, memory_data, load_ready
    );

    modport slave (
        input  memory_valid, memory_addr, load_valid, load_addr, load_data,
        output memory_ready, memory_data, load_ready
    );
endinterface

// File: rtl/instruction_memory_responder.sv
// Instruction memory server: answers CPU fetches and host program loads from one
// synchronous-read array, alternating grants fairly under contention.
module instruction_memory_responder #(
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11,
    parameter int unsigned MEMORY_DEPTH      = 2**MEMORY_ADDR_WIDTH,
    parameter int unsigned COUNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_memory_responder_if.slave bus,
    output logic [COUNT_WIDTH-1:0] fetch_count,
    output logic                   addr_error
);
    localparam int unsigned IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, F_READY, L_READY} state_t;
    typedef enum logic {GRANT_FETCH, GRANT_LOAD} grant_t;

    state_t                  state;
    grant_t                  last_grant;
    logic [MEMORY_WIDTH-1:0] memory_data_q;
    logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic             fetch_in_range;
    logic             load_in_range;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] load_idx;

    assign fetch_in_range = 32'(bus.memory_addr) < MEMORY_DEPTH;
    assign load_in_range  = 32'(bus.load_addr) < MEMORY_DEPTH;
    assign fetch_idx      = bus.memory_addr[IDX_W-1:0];
    assign load_idx       = bus.load_addr[IDX_W-1:0];

    assign bus.memory_ready = (state == F_READY);
    assign bus.load_ready   = (state == L_READY);
    assign bus.memory_data  = memory_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= GRANT_LOAD;
            memory_data_q <= '0;
            fetch_count   <= '0;
            addr_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the port not granted last wins.
                    if (bus.memory_valid && (!bus.load_valid || last_grant == GRANT_LOAD)) begin
                        state      <= F_READY;
                        last_grant <= GRANT_FETCH;
                    end else if (bus.load_valid) begin
                        state      <= L_READY;
                        last_grant <= GRANT_LOAD;
                    end
                end
                F_READY: begin
                    state <= IDLE;
                    if (bus.memory_valid) begin
                        fetch_count <= fetch_count + COUNT_WIDTH'(1);
                        if (fetch_in_range) begin
                            memory_data_q <= mem[fetch_idx];
                        end else begin
                            memory_data_q <= '0;
                            addr_error    <= 1'b1;
                        end
                    end
                end
                L_READY: begin
                    state <= IDLE;
                    if (bus.load_valid && !load_in_range) begin
                        addr_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents survive reset; reset only blocks a write in flight.
    always_ff @(posedge clk) begin
        if (!rst && state == L_READY && bus.load_valid && load_in_range) begin
            mem[load_idx] <= bus.load_data;
        end
    end
endmodule

// File: tb/tb_instruction_memory_responder.sv
// Randomized and directed bench for instruction_memory_responder, checked every
// cycle against a transaction-level model of grants, array contents and flags.
module tb_instruction_memory_responder;
    localparam int unsigned W     = 16;
    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 1000;
    localparam int unsigned CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] fetch_count;
    logic          addr_error;

    instruction_memory_responder_if #(.MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) bus ();

    instruction_memory_responder #(
        .MEMORY_WIDTH(W),
        .MEMORY_ADDR_WIDTH(AW),
        .MEMORY_DEPTH(DEPTH),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fetch_count(fetch_count),
        .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: which port is being offered ready this cycle, plus array and flags.
    bit          offer_f, offer_l, last_was_fetch;
    logic [W-1:0] m_data;
    bit          m_data_known = 1'b0;
    int unsigned m_count;
    bit          m_err;
    logic [W-1:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    always @(posedge clk) begin
        if (rst) begin
            offer_f = 0; offer_l = 0; last_was_fetch = 0;
            m_data = '0; m_data_known = 1; m_count = 0; m_err = 0;
        end else if (offer_f) begin
            offer_f = 0;
            if (bus.memory_valid) begin
                m_count++;
                if (int'(bus.memory_addr) < DEPTH) begin
                    m_data       = m_mem[int'(bus.memory_addr)];
                    m_data_known = m_known[int'(bus.memory_addr)];
                end else begin
                    m_data = '0; m_data_known = 1; m_err = 1;
                end
            end
        end else if (offer_l) begin
            offer_l = 0;
            if (bus.load_valid) begin
                if (int'(bus.load_addr) < DEPTH) begin
                    m_mem[int'(bus.load_addr)]   = bus.load_data;
                    m_known[int'(bus.load_addr)] = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            if (bus.memory_valid && (!bus.load_valid || !last_was_fetch)) begin
                offer_f = 1; last_was_fetch = 1;
            end else if (bus.load_valid) begin
                offer_l = 1; last_was_fetch = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("memory_ready", 32'(bus.memory_ready), 32'(offer_f));
            check("load_ready", 32'(bus.load_ready), 32'(offer_l));
            check("fetch_count", fetch_count, m_count);
            check("addr_error", 32'(addr_error), 32'(m_err));
            if (m_data_known) check("memory_data", 32'(bus.memory_data), 32'(m_data));
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, output int lat);
        bus.memory_valid = 1'b1;
        bus.memory_addr  = a;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (bus.memory_ready) break;
        end
        if (!bus.memory_ready) check("fetch_timeout", 32'(bus.memory_ready), 32'd1);
        @(negedge clk);
        bus.memory_valid = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_data  = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.load_ready) break;
        end
        if (!bus.load_ready) check("load_timeout", 32'(bus.load_ready), 32'd1);
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(990, 2047));
        return AW'($urandom_range(0, 63));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        bit f_drop, l_drop;
        bus.memory_valid = 0; bus.memory_addr = '0;
        bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0;

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; check_en = 1'b1;
        check("reset_data", 32'(bus.memory_data), 32'd0);
        check("reset_count", fetch_count, 32'd0);

        // Single load then fetch of the same word.
        do_load(11'd5, 16'h1234);
        do_fetch(11'd5, lat);
        check("t1_latency", lat, 32'd1);
        check("t1_data", 32'(bus.memory_data), 32'h1234);
        check("t1_count", fetch_count, 32'd1);
        check("t1_ready_low", 32'(bus.memory_ready), 32'd0);

        // Bulk load and back-to-back fetches.
        do_reset();
        for (int i = 0; i < 64; i++) do_load(AW'(i), {4'hA, 12'(i)});
        for (int i = 0; i < 64; i++) begin
            do_fetch(AW'(i), lat);
            if (i % 16 == 0) check("t2_word", 32'(bus.memory_data), 32'({4'hA, 12'(i)}));
        end
        check("t2_count", fetch_count, 32'd64);

        // Sustained contention: fetch first after reset, then alternate.
        do_reset();
        bus.memory_valid = 1; bus.memory_addr = 11'd10;
        bus.load_valid = 1; bus.load_addr = 11'd10; bus.load_data = 16'hBEEF;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            if (bus.memory_ready || bus.load_ready) begin
                check("grant_order", {30'b0, bus.memory_ready, bus.load_ready},
                      (k % 2 == 0) ? 32'b10 : 32'b01);
                k++;
            end
        end
        check("t3_grants", k, 32'd8);
        @(negedge clk);
        bus.memory_valid = 0; bus.load_valid = 0;
        check("t3_count", fetch_count, 32'd4);
        check("t3_data", 32'(bus.memory_data), 32'hBEEF);

        // Fetch withdrawn while ready is offered.
        bus.memory_valid = 1; bus.memory_addr = 11'd20;
        for (int c = 0; c < 20 && !bus.memory_ready; c++) @(negedge clk);
        bus.memory_valid = 0;
        @(negedge clk); @(negedge clk);
        check("t4_count", fetch_count, 32'd4);
        check("t4_data", 32'(bus.memory_data), 32'hBEEF);

        // Out-of-range fetch and load.
        do_load(11'd976, 16'h1111);
        do_fetch(11'd1500, lat);
        check("t5_data", 32'(bus.memory_data), 32'd0);
        check("t5_err", 32'(addr_error), 32'd1);
        do_load(11'd2000, 16'h2222);
        do_fetch(11'd976, lat);
        check("t5_alias", 32'(bus.memory_data), 32'h1111);
        check("t5_err_sticky", 32'(addr_error), 32'd1);

        // Reset while a load is being offered ready.
        do_load(11'd30, 16'h3333);
        bus.load_valid = 1; bus.load_addr = 11'd30; bus.load_data = 16'h4444;
        for (int c = 0; c < 20 && !bus.load_ready; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.load_valid = 0;
        check("t6_data", 32'(bus.memory_data), 32'd0);
        check("t6_count", fetch_count, 32'd0);
        check("t6_err", 32'(addr_error), 32'd0);
        check("t6_lready", 32'(bus.load_ready), 32'd0);
        do_fetch(11'd30, lat);
        check("t6_word", 32'(bus.memory_data), 32'h3333);

        // Random traffic on both ports with occasional withdrawals and resets.
        f_drop = 0; l_drop = 0;
        for (int it = 0; it < 800; it++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;

            if (bus.memory_valid) begin
                if (bus.memory_ready) begin
                    if ($urandom_range(0, 3) == 0) bus.memory_valid = 0;
                    else f_drop = 1;
                end else if (f_drop || $urandom_range(0, 15) == 0) begin
                    bus.memory_valid = 0; f_drop = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.memory_valid = 1; bus.memory_addr = rand_addr(); f_drop = 0;
            end

            if (bus.load_valid) begin
                if (bus.load_ready) begin
                    if ($urandom_range(0, 3) == 0) bus.load_valid = 0;
                    else l_drop = 1;
                end else if (l_drop || $urandom_range(0, 15) == 0) begin
                    bus.load_valid = 0; l_drop = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.load_valid = 1; bus.load_addr = rand_addr();
                bus.load_data = W'($urandom); l_drop = 0;
            end
        end
        bus.memory_valid = 0; bus.load_valid = 0; rst = 0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_memory_responder.md
# instruction_memory_responder

Instruction-memory server for the pipelined regex CPU. It answers the CPU's fetch port (memory_valid / memory_addr / memory_ready / memory_data) from an internal synchronous-read array. It also accepts program-load writes from the host side. It resolves contention between fetches and loads with a fair alternating arbiter, keeps a fetch counter, and flags out-of-range accesses.

## Interface
Parameters:
- MEMORY_WIDTH, 16, instruction word width
- MEMORY_ADDR_WIDTH, 11, address width on both ports
- MEMORY_DEPTH, 2**MEMORY_ADDR_WIDTH, implemented words; must be ≤ 2**MEMORY_ADDR_WIDTH
- COUNT_WIDTH, 32, fetch counter width

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- memory_valid  in  1  CPU fetch request
- memory_addr  in  MEMORY_ADDR_WIDTH  fetch address, stable while memory_valid=1
- memory_ready  out  1  responder accepts the fetch this cycle
- memory_data  out  MEMORY_WIDTH  fetched instruction word
- load_valid  in  1  host write request
- load_addr  in  MEMORY_ADDR_WIDTH  write address
- load_data  in  MEMORY_WIDTH  write word
- load_ready  out  1  responder accepts the write this cycle
- fetch_count  out  COUNT_WIDTH  number of accepted fetches
- addr_error  out  1  sticky flag: an accepted access had an address ≥ MEMORY_DEPTH

## Operation
- FSM with three states: IDLE, F_READY, L_READY. memory_ready is 1 only in F_READY; load_ready is 1 only in L_READY. Both are decoded from the state register, with no combinational path from the inputs.
- IDLE transitions:
  - Only memory_valid=1 → F_READY.
  - Only load_valid=1 → L_READY.
  - Both =1 → grant the port not granted last (last_grant register). Update last_grant on every grant.
  - Neither → stay in IDLE.
- F_READY:
  - If memory_valid=1 the fetch is accepted. Read array[memory_addr] and register it into memory_data. Increment fetch_count, wrapping modulo 2**COUNT_WIDTH. Go to IDLE.
  - If memory_valid=0 the request was withdrawn. Go to IDLE; no read, memory_data unchanged.
- L_READY:
  - If load_valid=1, write array[load_addr] ← load_data and go to IDLE.
  - Otherwise go to IDLE with no write.
- memory_data holds its last value until the next accepted fetch.
- Out-of-range address (≥ MEMORY_DEPTH) on an accepted fetch: memory_data ← 0 and addr_error ← 1. On an accepted load: no write and addr_error ← 1. The count still increments for a fetch.
- Array contents are not reset. After rst the program must be reloaded; reads of unloaded words are undefined.
- rst mid-operation (any state) overrides everything in that cycle. An in-flight access is dropped: no write, no count.

## Timing
- Reset values: state IDLE, memory_ready 0, load_ready 0, memory_data 0, fetch_count 0, addr_error 0, last_grant = load (the first tie goes to fetch).
- Fetch latency:
  - memory_valid is seen in cycle N.
  - memory_ready=1 in cycle N+1. Acceptance happens at the end of N+1 if memory_valid is still 1.
  - memory_data is valid from cycle N+2 onward.
  - memory_ready=0 in N+2.
- The earliest next memory_ready is N+3. A port never sees ready on two consecutive cycles.
- Load latency: load_valid seen in cycle N → load_ready=1 in N+1, write at the end of N+1. A fetch of the same address granted afterwards returns the new word.
- Fetch and load are never accepted in the same cycle.
- Sustained contention: grants alternate fetch, load, fetch, …, one access per 2 cycles. Neither port starves.

## Test plan
- Reset, then load 0x1234 at address 5. Fetch address 5: memory_ready high exactly one cycle after memory_valid → memory_data=0x1234 the cycle after acceptance, ready low, fetch_count=1.
- Load addresses 0..63 with {4'h?, addr}. Run 64 back-to-back fetches, with the CPU dropping valid one cycle after acceptance → every word matches, fetch_count=64, ready never high on two consecutive cycles.
- Assert memory_valid and load_valid together for 8 grants → order is F,L,F,L,F,L,F,L, with 4 writes and 4 fetches.
- Raise memory_valid, then drop it during F_READY → FSM returns to IDLE, memory_data unchanged, fetch_count unchanged.
- With MEMORY_DEPTH=1000, fetch address 1500 → memory_data=0, addr_error=1 and it stays 1. Then load address 2000 → no array change.
- Assert rst while in L_READY with load_valid=1 → target word unchanged, all outputs return to their reset values on the next cycle.
